// File: rtl/id_ex_ctrl_reg.sv
// ----------------------------------------------------------------------------
// id_ex_ctrl_reg
//
// ID/EX pipeline register for the control-unit fields, with load-use hazard
// detection. A load in EX whose destination is read by the instruction in ID
// causes exactly one bubble: stall_o freezes PC and IF/ID while a bubble is
// loaded into EX. flush_i annuls the ID instruction (taken branch/CALL/JMPL).
// hold_i freezes the whole register.
//
// Bubble encoding: every field zero except size_o = 2'b10.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   soh_op_i, alu_op_i    4-bit operand-handler / ALU codes
//   rw_i .. se_i          1-bit control strobes
//   size_i, id_sr_i       2-bit size, 3-bit id_sr field
//   rs1_i, rs2_i, rd_i    5-bit register fields, i_bit_i immediate flag
//   flush_i, hold_i       annul / global freeze
//   *_o                   registered copies of every field above
//   stall_o               combinational PC / IF-ID freeze request
//   bubble_cnt_o,
//   flush_cnt_o           16-bit saturating event counters, present only when
//                         the ID_EX_STATS_EN macro is defined
// ----------------------------------------------------------------------------
module id_ex_ctrl_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  soh_op_i,
    input  logic [3:0]  alu_op_i,
    input  logic        rw_i,
    input  logic        e_i,
    input  logic        cc_we_i,
    input  logic        use_cc_i,
    input  logic        j_l_i,
    input  logic        call_i,
    input  logic        rf_le_i,
    input  logic        b_i,
    input  logic        l_i,
    input  logic        se_i,
    input  logic [1:0]  size_i,
    input  logic [2:0]  id_sr_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        i_bit_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic [3:0]  soh_op_o,
    output logic [3:0]  alu_op_o,
    output logic        rw_o,
    output logic        e_o,
    output logic        cc_we_o,
    output logic        use_cc_o,
    output logic        j_l_o,
    output logic        call_o,
    output logic        rf_le_o,
    output logic        b_o,
    output logic        l_o,
    output logic        se_o,
    output logic [1:0]  size_o,
    output logic [2:0]  id_sr_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        i_bit_o,
`ifdef ID_EX_STATS_EN
    output logic [15:0] bubble_cnt_o,
    output logic [15:0] flush_cnt_o,
`endif
    output logic        stall_o
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] soh_op;
        logic [3:0] alu_op;
        logic       rw;
        logic       e;
        logic       cc_we;
        logic       use_cc;
        logic       j_l;
        logic       call;
        logic       rf_le;
        logic       b;
        logic       l;
        logic       se;
        logic [1:0] size;
        logic [2:0] id_sr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       i_bit;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{size: 2'b10, default: '0};

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, ctrl_in;
    logic   load_use;

    assign ctrl_in = '{
        soh_op: soh_op_i, alu_op: alu_op_i,
        rw: rw_i, e: e_i, cc_we: cc_we_i, use_cc: use_cc_i, j_l: j_l_i,
        call: call_i, rf_le: rf_le_i, b: b_i, l: l_i, se: se_i,
        size: size_i, id_sr: id_sr_i,
        rs1: rs1_i, rs2: rs2_i, rd: rd_i, i_bit: i_bit_i
    };

    // rs2 is only a source when the instruction is not immediate; rd is a
    // source only for stores (rw_i=1 carries the store data register).
    // Register 0 is hardwired, so a load into it never creates a hazard.
    assign load_use = ctrl_q.l && (ctrl_q.rd != 5'd0) &&
                      ((ctrl_q.rd == rs1_i) ||
                       (!i_bit_i && (ctrl_q.rd == rs2_i)) ||
                       (rw_i && (ctrl_q.rd == rd_i)));

`ifdef ID_EX_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        bubble_inc, flush_inc;

    assign bubble_cnt_o = bubble_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        stall_o = 1'b0;
`ifdef ID_EX_STATS_EN
        bubble_inc = 1'b0;
        flush_inc  = 1'b0;
`endif
        if (flush_i) begin
            ctrl_d  = CTRL_BUBBLE;
            state_d = ST_RUN;
`ifdef ID_EX_STATS_EN
            flush_inc = 1'b1;
`endif
        end else if (hold_i) begin
            // everything keeps its value; stall_o stays low
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (load_use) begin
                        stall_o = 1'b1;
                        ctrl_d  = CTRL_BUBBLE;
                        state_d = ST_BUBBLE;
`ifdef ID_EX_STATS_EN
                        bubble_inc = 1'b1;
`endif
                    end else begin
                        ctrl_d = ctrl_in;
                    end
                end
                ST_BUBBLE: begin
                    ctrl_d  = ctrl_in;
                    state_d = ST_RUN;
                end
                default: begin
                    ctrl_d  = CTRL_BUBBLE;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

`ifdef ID_EX_STATS_EN
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_inc && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign soh_op_o = ctrl_q.soh_op;
    assign alu_op_o = ctrl_q.alu_op;
    assign rw_o     = ctrl_q.rw;
    assign e_o      = ctrl_q.e;
    assign cc_we_o  = ctrl_q.cc_we;
    assign use_cc_o = ctrl_q.use_cc;
    assign j_l_o    = ctrl_q.j_l;
    assign call_o   = ctrl_q.call;
    assign rf_le_o  = ctrl_q.rf_le;
    assign b_o      = ctrl_q.b;
    assign l_o      = ctrl_q.l;
    assign se_o     = ctrl_q.se;
    assign size_o   = ctrl_q.size;
    assign id_sr_o  = ctrl_q.id_sr;
    assign rs1_o    = ctrl_q.rs1;
    assign rs2_o    = ctrl_q.rs2;
    assign rd_o     = ctrl_q.rd;
    assign i_bit_o  = ctrl_q.i_bit;

endmodule

// File: doc/id_ex_ctrl_reg.md
ID_EX_CTRL_REG -- requirements
Module: id_ex_ctrl_reg

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: soh_op_i/alu_op_i  in  4/4  control-unit operand-handler and ALU codes.
REQ-004 SHALL provide: rw_i, e_i, cc_we_i, use_cc_i, j_l_i, call_i, rf_le_i, b_i, l_i, se_i  in  1 each  control-unit strobes.
REQ-005 SHALL provide: size_i  in  2;  id_sr_i  in  3  control-unit fields.
REQ-006 SHALL provide: rs1_i, rs2_i, rd_i  in  5 each  ID-stage register fields;  i_bit_i  in  1  immediate flag.
REQ-007 SHALL provide: flush_i  in  1  taken branch/CALL/JMPL annul;  hold_i  in  1  global pipeline freeze.
REQ-008 SHALL provide: registered copies of all REQ-003..006 fields with suffix _o, same widths.
REQ-009 SHALL provide: stall_o  out  1  combinational, freezes PC and IF/ID when 1.
REQ-010 SHALL provide (macro-gated): bubble_cnt_o, flush_cnt_o  out  16 each.

Function
REQ-011 SHALL register every _i field into its _o on each rising edge when no bubble, flush or hold applies (latency 1 cycle).
REQ-012 SHALL define a bubble as all control outputs zero except size_o=2'b10; register fields zero.
REQ-013 SHALL detect load-use: l_o=1, rd_o!=0, and rd_o equals rs1_i, or rs2_i when i_bit_i=0, or rd_i when rw_i=1 (store data).
REQ-014 SHALL run a two-state FSM: RUN (reset) and BUBBLE.
REQ-015 RUN: on load-use, stall_o=1, load a bubble, go to BUBBLE; else normal capture, stay RUN.
REQ-016 BUBBLE: stall_o=0, hazard detection suppressed, normal capture, return to RUN (exactly one bubble per load-use).
REQ-017 SHALL give priority flush_i > hold_i > load-use > normal capture.
REQ-018 flush_i=1 SHALL load a bubble, force RUN, drive stall_o=0, regardless of hold_i.
REQ-019 hold_i=1 (no flush) SHALL freeze all outputs, FSM state and counters; stall_o SHALL be 0.
REQ-020 rd_o=0 SHALL never raise a hazard (register 0 is hardwired).
REQ-021 Back-to-back loads with dependency SHALL each produce one bubble.

Reset
REQ-022 rst_n=0 SHALL asynchronously load a bubble into all outputs (size_o=2'b10, rest 0), FSM RUN, counters 0.
REQ-023 Reset asserted mid-BUBBLE SHALL abandon the stall; stall_o=0 on first cycle after release.

Configuration
REQ-024 Macro ID_EX_STATS_EN SHALL, when defined, compile in bubble_cnt_o (incremented per REQ-015 bubble) and flush_cnt_o (incremented per accepted flush_i); both 16-bit saturating at 16'hFFFF.
REQ-025 Without ID_EX_STATS_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-026 Reset: rst_n=0 mid-cycle -> outputs zero immediately, size_o=2'b10, stall_o=0.
REQ-027 Pass-through: ADDcc (alu_op_i=4'b0000, cc_we_i=1, rf_le_i=1, rd_i=5) -> same values on _o next edge, stall_o=0.
REQ-028 Load-use: ld rd=3 in EX, then add rs1_i=3 -> stall_o=1 one cycle, bubble in EX, add enters next cycle, bubble_cnt_o=1.
REQ-029 No hazard: ld rd=0, then rs1_i=0; and ld rd=4 with rs2_i=4, i_bit_i=1 -> stall_o stays 0.
REQ-030 Flush vs hold: flush_i=1 with hold_i=1 while in BUBBLE -> bubble loaded, FSM RUN, flush_cnt_o increments by 1.
REQ-031 Saturation (ID_EX_STATS_EN): 65537 flushes -> flush_cnt_o=16'hFFFF.
